muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Sequences RV32M instructions for the execute stage.
- MUL/MULH/MULHSU/MULHU are issued to the shared combinational ALU through its one-hot select lines. The ALU result is captured one cycle later.
- DIV/DIVU/REM/REMU run on an internal 32-iteration restoring divider, because the ALU has no divide path.
- Requests and responses use valid/ready handshakes, so the pipeline can stall on busy.

Parameters:
- WIDTH, 32, operand and result width; the divider iterates WIDTH times.
- TAG_W, 5, width of the destination-register tag carried from request to response.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; drops any in-flight operation.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- req_a  input  WIDTH  rs1 value.
- req_b  input  WIDTH  rs2 value.
- req_tag  input  TAG_W  rd tag.
- alu_operand_a  output  WIDTH  ALU operand a.
- alu_operand_b  output  WIDTH  ALU operand b.
- alu_sel_mul, alu_sel_mulh, alu_sel_mulhsu, alu_sel_mulhu  output  1 each  one-hot ALU selects.
- alu_result  input  WIDTH  ALU combinational result.
- resp_valid  output  1  result present.
- resp_ready  input  1  consumer accepts result.
- resp_data  output  WIDTH  result.
- resp_tag  output  TAG_W  rd tag of result.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low, async):
  - state to IDLE.
  - All registers cleared.
  - req_ready=1; resp_valid=0; resp_data=0; resp_tag=0; busy=0.
  - All alu_sel_* = 0; alu_operand_a/b = 0.
- States: IDLE, MUL, DIV, FIX, DONE.
- Request acceptance:
  - req_ready = (state==IDLE). A request is accepted on an edge where req_valid && req_ready.
  - On acceptance, req_a, req_b, req_op and req_tag are latched into op_a, op_b, op_r and tag_r.
- IDLE -> MUL when req_op[2]==0.
- MUL state:
  - alu_operand_a=op_a and alu_operand_b=op_b.
  - Exactly the alu_sel_* matching op_r is high.
  - On the next edge, alu_result is captured into resp_data, then go to DONE.
  - Multiply latency: resp_valid rises 2 cycles after the accept edge.
- alu_sel_* are all 0 in every state except MUL. The ALU operand outputs hold their last registered values in all other states.
- IDLE -> DIV when req_op[2]==1 and there is no special case. At acceptance:
  - Signed ops (DIV, REM): operands are converted to magnitudes. Quotient sign = a[MSB]^b[MSB]; remainder sign = a[MSB].
  - Unsigned ops (DIVU, REMU): signs are 0.
- DIV state, each cycle:
  - Shift {rem,quo} left by 1.
  - Trial = rem - divisor (WIDTH+1 bits). If non-negative, rem=trial and quo[0]=1.
  - Iteration counter runs 0..WIDTH-1; after the WIDTH-th iteration go to FIX.
- FIX state:
  - Negate quotient and/or remainder per the stored signs.
  - resp_data = quotient for DIV/DIVU, remainder for REM/REMU. Go to DONE.
- Divide latency: resp_valid rises WIDTH+2 = 34 cycles after the accept edge.
- Special cases are resolved at acceptance and go straight IDLE -> DONE; resp_valid is high the cycle after accept.
  - Divide by zero (b==0): DIV/DIVU give all ones; REM/REMU give a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- DONE state:
  - resp_valid=1; resp_data and resp_tag are held stable until resp_valid && resp_ready.
  - On that handshake go to IDLE.
  - There is no same-cycle re-accept: req_ready is 0 in DONE, so the next request is accepted at the earliest one cycle after the response handshake.
- flush:
  - From any state, go to IDLE on the next edge. resp_valid falls and the result is discarded.
  - flush wins over a simultaneous req_valid or response handshake; nothing is accepted on that edge.
- Reset mid-operation aborts immediately; no response is produced.
- resp_tag always equals the tag of the request that produced resp_data.

Test Plan:
- MULH: a=0xFFFFFFFF (-1), b=0x00000002.
  - Sequence: accept -> MUL cycle with alu_sel_mulh=1 and other selects 0.
  - Required: resp_valid 2 cycles after accept; ALU model returns 0xFFFFFFFF; resp_data=0xFFFFFFFF, resp_tag echoes the request tag.
- DIV: a=-7 (0xFFFFFFF9), b=2.
  - Required: resp_data=0xFFFFFFFD (-3) after 34 cycles.
  - Repeat as REM: resp_data=0xFFFFFFFF (-1).
  - Repeat as DIVU: resp_data=0x7FFFFFFC.
- Divide by zero: DIVU a=0x1234, b=0 -> resp_data=0xFFFFFFFF one cycle after accept.
  - REMU with the same operands -> resp_data=0x1234.
- Signed overflow: DIV a=0x80000000, b=0xFFFFFFFF -> resp_data=0x80000000.
  - REM with the same operands -> resp_data=0.
  - Both responses arrive one cycle after accept.
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid.
  - Required: resp_data and resp_tag stable; req_ready=0 and busy=1 throughout.
  - Raise resp_ready: handshake, then req_ready=1 on the next cycle.
- Abort: assert flush at DIV iteration 10 -> IDLE next cycle, no resp_valid, new request accepted.
  - Separately, pull rst_n low mid-MUL: all outputs go to reset values asynchronously.

Source files
------------

// File: rtl/muldiv_sequencer_if.sv
// Request/response handshake bundle between the execute stage and the
// RV32M multiply/divide sequencer.
interface muldiv_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_data;
  logic [TAG_W-1:0] resp_tag;

  // Requester side (pipeline)
  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  // Sequencer side
  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// RV32M sequencer: multiplies go through the shared combinational ALU
// (one cycle in MUL, result captured on the following edge); divides and
// remainders run on an internal restoring divider, one bit per cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  muldiv_sequencer_if.slave   bus,
  output logic [WIDTH-1:0]    alu_operand_a,
  output logic [WIDTH-1:0]    alu_operand_b,
  output logic                alu_sel_mul,
  output logic                alu_sel_mulh,
  output logic                alu_sel_mulhsu,
  output logic                alu_sel_mulhu,
  input  logic [WIDTH-1:0]    alu_result,
  output logic                busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] INT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] op_a, op_b;
  logic [2:0]       op_r;
  logic [TAG_W-1:0] tag_r;
  logic [WIDTH-1:0] rem, quo, divisor;
  logic [CNT_W-1:0] cnt;
  logic             q_neg, r_neg;
  logic [WIDTH-1:0] resp_data_r;

  logic             accept;
  logic             signed_op;
  logic             div_by_zero;
  logic             overflow;
  logic             special;
  logic [WIDTH-1:0] special_result;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   partial, trial;
  logic [WIDTH-1:0] quo_fixed, rem_fixed;

  assign accept      = bus.req_valid && (state == ST_IDLE);
  assign signed_op   = ~bus.req_op[0];
  assign div_by_zero = (bus.req_b == '0);
  assign overflow    = signed_op && (bus.req_a == INT_MIN) && (bus.req_b == '1);
  assign special     = bus.req_op[2] && (div_by_zero || overflow);
  assign mag_a       = (signed_op && bus.req_a[WIDTH-1]) ? -bus.req_a : bus.req_a;
  assign mag_b       = (signed_op && bus.req_b[WIDTH-1]) ? -bus.req_b : bus.req_b;

  // Shifted partial remainder and trial subtraction for one divider step
  assign partial   = {rem, quo[WIDTH-1]};
  assign trial     = partial - {1'b0, divisor};
  assign quo_fixed = q_neg ? -quo : quo;
  assign rem_fixed = r_neg ? -rem : rem;

  // Results that bypass the divider: divide by zero and signed overflow
  always_comb begin
    special_result = '0;
    if (div_by_zero) begin
      special_result = bus.req_op[1] ? bus.req_a : '1;
    end else if (overflow) begin
      special_result = bus.req_op[1] ? '0 : bus.req_a;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; flush overrides everything, including the handshakes
  always_comb begin
    state_next = state;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (!bus.req_op[2])  state_next = ST_MUL;
            else if (special)    state_next = ST_DONE;
            else                 state_next = ST_DIV;
          end
        end
        ST_MUL:  state_next = ST_DONE;
        ST_DIV:  if (cnt == CNT_LAST) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        ST_DONE: if (bus.resp_ready) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Operand latching, divider iterations and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a        <= '0;
      op_b        <= '0;
      op_r        <= '0;
      tag_r       <= '0;
      rem         <= '0;
      quo         <= '0;
      divisor     <= '0;
      cnt         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      resp_data_r <= '0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_a  <= bus.req_a;
            op_b  <= bus.req_b;
            op_r  <= bus.req_op;
            tag_r <= bus.req_tag;
            if (special) begin
              resp_data_r <= special_result;
            end else if (bus.req_op[2]) begin
              rem     <= '0;
              quo     <= mag_a;
              divisor <= mag_b;
              cnt     <= '0;
              q_neg   <= signed_op && (bus.req_a[WIDTH-1] ^ bus.req_b[WIDTH-1]);
              r_neg   <= signed_op && bus.req_a[WIDTH-1];
            end
          end
        end
        ST_MUL: resp_data_r <= alu_result;
        ST_DIV: begin
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            rem <= partial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], 1'b0};
          end
          cnt <= cnt + CNT_W'(1);
        end
        ST_FIX: resp_data_r <= op_r[1] ? rem_fixed : quo_fixed;
        default: ;
      endcase
    end
  end

  // One-hot ALU select, active only while the multiply is on the ALU
  always_comb begin
    alu_sel_mul    = 1'b0;
    alu_sel_mulh   = 1'b0;
    alu_sel_mulhsu = 1'b0;
    alu_sel_mulhu  = 1'b0;
    if (state == ST_MUL && !op_r[2]) begin
      case (op_r[1:0])
        2'b00:   alu_sel_mul    = 1'b1;
        2'b01:   alu_sel_mulh   = 1'b1;
        2'b10:   alu_sel_mulhsu = 1'b1;
        default: alu_sel_mulhu  = 1'b1;
      endcase
    end
  end

  assign alu_operand_a  = op_a;
  assign alu_operand_b  = op_b;
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.resp_valid = (state == ST_DONE);
  assign bus.resp_data  = resp_data_r;
  assign bus.resp_tag   = tag_r;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [31:0] alu_operand_a, alu_operand_b;
  logic        alu_sel_mul, alu_sel_mulh, alu_sel_mulhsu, alu_sel_mulhu;
  logic [31:0] alu_result;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  muldiv_sequencer_if #(.WIDTH(32), .TAG_W(5)) bus ();

  muldiv_sequencer #(.WIDTH(32), .TAG_W(5)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush          (flush),
    .bus            (bus.slave),
    .alu_operand_a  (alu_operand_a),
    .alu_operand_b  (alu_operand_b),
    .alu_sel_mul    (alu_sel_mul),
    .alu_sel_mulh   (alu_sel_mulh),
    .alu_sel_mulhsu (alu_sel_mulhsu),
    .alu_sel_mulhu  (alu_sel_mulhu),
    .alu_result     (alu_result),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU model; a marker value when nothing is selected
  always_comb begin
    logic [63:0] p;
    p = 64'hDEAD_BEEF_DEAD_BEEF;
    if (alu_sel_mul)    p = {32'b0, alu_operand_a} * {32'b0, alu_operand_b};
    if (alu_sel_mulh)   p = 64'(longint'($signed(alu_operand_a)) * longint'($signed(alu_operand_b))) >> 32;
    if (alu_sel_mulhsu) p = 64'(longint'($signed(alu_operand_a)) * longint'({32'b0, alu_operand_b})) >> 32;
    if (alu_sel_mulhu)  p = ({32'b0, alu_operand_a} * {32'b0, alu_operand_b}) >> 32;
    alu_result = p[31:0];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    case (op)
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: p = 64'(sa * sb) >> 32;
      3'd2: p = 64'(sa * longint'({32'b0, b})) >> 32;
      3'd3: p = ({32'b0, a} * {32'b0, b}) >> 32;
      3'd4: begin
        if (b == 0) p = 64'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'b0, a};
        else p = 64'(sa / sb);
      end
      3'd5: p = (b == 0) ? 64'hFFFF_FFFF : {32'b0, a / b};
      3'd6: begin
        if (b == 0) p = {32'b0, a};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = '0;
        else p = 64'(sa % sb);
      end
      default: p = (b == 0) ? {32'b0, a} : {32'b0, a % b};
    endcase
    return p[31:0];
  endfunction

  // Cycles from the accept cycle (counted as 1) to the first cycle with resp_valid
  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) return 2;
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
    @(negedge clk);
    check("req_ready_idle", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_a     = $urandom;
    bus.req_b     = $urandom;
    bus.req_tag   = 5'($urandom);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, input int stall);
    logic [31:0] exp;
    int          k;
    exp = ref_result(op, a, b);
    issue(op, a, b, tag);
    k = 1;
    @(negedge clk);
    if (!op[2]) begin
      check("alu_sel", 64'({alu_sel_mul, alu_sel_mulh, alu_sel_mulhsu, alu_sel_mulhu}),
            64'(4'b1000 >> op[1:0]));
      check("alu_opnd", {alu_operand_a, alu_operand_b}, {a, b});
    end
    while (!bus.resp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(ref_latency(op, a, b)));
    check("resp_data", 64'(bus.resp_data), 64'(exp));
    check("resp_tag", 64'(bus.resp_tag), 64'(tag));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("hold_data", 64'(bus.resp_data), 64'(exp));
      check("hold_tag", 64'(bus.resp_tag), 64'(tag));
      check("hold_flags", 64'({bus.resp_valid, bus.req_ready, busy}), 64'(3'b101));
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    check("post_hs", 64'({bus.resp_valid, bus.req_ready, busy}), 64'(3'b010));
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          vis;

    rst_n          = 1'b0;
    flush          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_op     = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.req_tag    = '0;
    bus.resp_ready = 1'b0;
    #12;
    check("rst_flags", 64'({bus.req_ready, bus.resp_valid, busy}), 64'(3'b100));
    check("rst_resp", {bus.resp_data, 27'b0, bus.resp_tag}, 64'd0);
    check("rst_alu", {alu_operand_a, alu_operand_b}, 64'd0);
    check("rst_sel", 64'({alu_sel_mul, alu_sel_mulh, alu_sel_mulhsu, alu_sel_mulhu}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run_op(3'd1, 32'hFFFF_FFFF, 32'h2, 5'd9, 0);
    run_op(3'd4, 32'hFFFF_FFF9, 32'h2, 5'd3, 0);
    run_op(3'd6, 32'hFFFF_FFF9, 32'h2, 5'd4, 0);
    run_op(3'd5, 32'hFFFF_FFF9, 32'h2, 5'd5, 0);
    run_op(3'd5, 32'h1234, 32'h0, 5'd6, 0);
    run_op(3'd7, 32'h1234, 32'h0, 5'd7, 0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
    run_op(3'd0, 32'h0001_0003, 32'h0000_0007, 5'd31, 5);

    // Flush during divider iteration 10, then a fresh request must work
    issue(3'd4, 32'h0123_4567, 32'h0000_0089, 5'd12);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'({bus.resp_valid, bus.req_ready, busy}), 64'(3'b010));
    vis = 0;
    repeat (4) begin
      @(negedge clk);
      vis += int'(bus.resp_valid);
    end
    check("flush_no_resp", 64'(vis), 64'd0);
    run_op(3'd7, 32'h0123_4567, 32'h0000_0089, 5'd13, 1);

    // Flush beats a simultaneous request
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    flush         = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    flush         = 1'b0;
    check("flush_vs_req", 64'(busy), 64'd0);

    // Asynchronous reset while the multiply is on the ALU
    issue(3'd3, 32'hCAFE_F00D, 32'h1357_9BDF, 5'd17);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("amid_flags", 64'({bus.req_ready, bus.resp_valid, busy}), 64'(3'b100));
    check("amid_resp", {bus.resp_data, 27'b0, bus.resp_tag}, 64'd0);
    check("amid_alu", {alu_operand_a, alu_operand_b}, 64'd0);
    check("amid_sel", 64'({alu_sel_mul, alu_sel_mulh, alu_sel_mulhsu, alu_sel_mulhu}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("amid_no_resp", 64'(bus.resp_valid), 64'd0);

    // Randomized mix including corner operands
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(op, a, b, 5'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
